uart_port: RTL and testbench
============================

// Module: uart_port
// PURPOSE
//  Device side of the CPU's UART strobe interface: responds to wrn/rdn and drives
//  data_ready/tbre/tsre, the way an external UART chip does. Serialises written bytes
//  on txd and deserialises rxd into a one-byte receive buffer.
//  Sits below the CPU top level, in place of the board UART chip, on the low byte of
//  the Ram1 data bus.
// PARAMETERS
//  CLKS_PER_BIT  96  CLK cycles per serial bit (11.0592 MHz / 115200); >=4, even
// PORTS
//  CLK          in   1  single clock; all state on rising edge
//  RST          in   1  asynchronous, active-low reset
//  din          in   8  byte to transmit, sampled when a wrn rising edge is detected
//  dout         out  8  receive buffer contents, always driven (CPU gates with rdn)
//  wrn          in   1  active-low write strobe from CPU, asynchronous to CLK
//  rdn          in   1  active-low read strobe from CPU, asynchronous to CLK
//  data_ready   out  1  1 = unread byte in receive buffer
//  tbre         out  1  1 = transmit holding register empty
//  tsre         out  1  1 = transmit shift register idle (line quiet)
//  txd          out  1  serial out; idle high; 8N1, LSB first
//  rxd          in   1  serial in, asynchronous
//  rx_overrun   out  1  sticky: byte arrived while data_ready=1; cleared on read
//  rx_frame_err out  1  one-cycle pulse: stop bit sampled low
// BEHAVIOUR
//  Reset (RST=0, immediate): txd=1, tbre=1, tsre=1, data_ready=0, dout=0,
//   rx_overrun=0, rx_frame_err=0, both FSMs to IDLE, synchronisers preset to 1.
//   Reset mid-frame aborts the frame; txd goes high at once.
//  Sync: wrn, rdn, rxd each pass through 2 flops. Edge detect uses the 2nd and 3rd
//   flops, so an edge acts on the 3rd CLK edge after the pin changes.
//  Write: wrn rising edge with tbre=1 -> holding <= din, tbre <= 0.
//   With tbre=0 the write is dropped and holding is unchanged.
//  Transfer: tbre=0 and tsre=1 -> next cycle shifter <= holding, tbre <= 1, tsre <= 0,
//   TX FSM leaves IDLE.
//   A second byte may be written while the first is shifting.
//  TX FSM:
//   IDLE  -> START when a transfer occurs.
//   START -> DATA after 1 bit time; txd=0.
//   DATA  8 bit times, LSB first.
//   STOP  1 bit time, txd=1.
//   After STOP: tsre <= 1 and -> IDLE.
//   If holding is full at STOP end, the next transfer starts on the following cycle
//   (tsre pulses high 1 cycle).
//  RX FSM:
//   IDLE  -> START on synced rxd falling edge.
//   START wait CLKS_PER_BIT/2; if rxd=1 it is a glitch -> IDLE, else -> DATA.
//   DATA  sample every CLKS_PER_BIT, 8 bits into the shift register, LSB first.
//   STOP  sample after CLKS_PER_BIT:
//    rxd=1 -> dout <= shift and data_ready <= 1; rx_overrun <= 1 if data_ready was
//     already 1 (old byte overwritten).
//    rxd=0 -> pulse rx_frame_err, buffer untouched.
//    Either way -> IDLE.
//  Read: rdn rising edge -> data_ready <= 0, rx_overrun <= 0. dout is unchanged.
//  Simultaneous: a byte commit and an rdn rising edge in the same cycle -> the commit
//   wins: data_ready stays 1, dout = new byte, rx_overrun unchanged.
//   A wrn edge coinciding with the transfer cycle cannot occur, because a transfer
//   needs tbre=0.
//  Counters: bit-timer counts 0..CLKS_PER_BIT-1 and wraps; bit index 0..7.
//   One timer per FSM; both FSMs are independent, so full duplex is supported.
// TESTING (bench uses CLKS_PER_BIT=16)
//  1 Reset then idle 100 cycles -> txd=1, tbre=1, tsre=1, data_ready=0, dout=8'h00.
//  2 din=8'hA5, pulse wrn low 4 cycles -> tbre low within 3 cycles of the rise, then high
//    1 cycle later; txd shows 0,1,0,1,0,0,1,0,1,1 at 16 cycles/bit; tsre=1 after stop.
//  3 Two back-to-back writes (8'h55 then 8'h0F) -> both frames on txd with no gap >1
//    cycle; a third write while tbre=0 is dropped and never transmitted.
//  4 Drive rxd with 8'h3C frame -> data_ready=1, dout=8'h3C; pulse rdn -> data_ready=0.
//    A second frame 8'h81 sent unread -> dout=8'h81, rx_overrun=1; rdn clears both flags.
//  5 rxd low 4 cycles only -> no frame, data_ready stays 0. A frame with stop=0 ->
//    one-cycle rx_frame_err, dout unchanged.
//  6 Assert RST mid-TX (bit 3) and mid-RX -> txd=1 immediately, flags at reset values;
//    the next full frame after release is received and transmitted correctly.

Source files
------------

// File: rtl/uart_port.sv
// uart_port: device side of the CPU UART strobe interface, standing in for the
// board UART chip on the low byte of the Ram1 data bus. A CPU write (rising edge
// of wrn) loads the transmit holding register. The byte is then sent on txd as
// 8N1, LSB first. Frames arriving on rxd are collected into a one-byte receive
// buffer, which the CPU acknowledges with a rising edge of rdn.
//
// Ports
//   CLK          single clock, all state on the rising edge
//   RST          asynchronous active-low reset
//   din          byte to transmit, sampled on a detected wrn rising edge
//   dout         receive buffer contents, always driven
//   wrn, rdn     active-low CPU strobes, asynchronous to CLK
//   data_ready   unread byte present in the receive buffer
//   tbre         transmit holding register empty
//   tsre         transmit shift register idle
//   txd          serial output, idle high
//   rxd          serial input, asynchronous
//   rx_overrun   sticky: a byte arrived while data_ready was set, cleared by a read
//   rx_frame_err one-cycle pulse when the stop bit is sampled low
module uart_port #(
    parameter int unsigned CLKS_PER_BIT = 96
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       wrn,
    input  logic       rdn,
    output logic       data_ready,
    output logic       tbre,
    output logic       tsre,
    output logic       txd,
    input  logic       rxd,
    output logic       rx_overrun,
    output logic       rx_frame_err
);

    localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // Synchronisers: bit 0 is the first flop and bit 2 is the edge-detect history.
    logic [2:0] wrn_sync, rdn_sync, rxd_sync;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wrn_sync <= 3'b111;
            rdn_sync <= 3'b111;
            rxd_sync <= 3'b111;
        end else begin
            wrn_sync <= {wrn_sync[1:0], wrn};
            rdn_sync <= {rdn_sync[1:0], rdn};
            rxd_sync <= {rxd_sync[1:0], rxd};
        end
    end

    logic wr_rise, rd_rise, rx_fall, rx_bit;
    assign wr_rise = wrn_sync[1] & ~wrn_sync[2];
    assign rd_rise = rdn_sync[1] & ~rdn_sync[2];
    assign rx_fall = ~rxd_sync[1] & rxd_sync[2];
    assign rx_bit  = rxd_sync[1];

    // Transmit path state
    logic [1:0]    tx_state, tx_state_n;
    logic [TW-1:0] tx_timer, tx_timer_n;
    logic [2:0]    tx_idx, tx_idx_n;
    logic [7:0]    tx_shift, tx_shift_n;
    logic [7:0]    holding, holding_n;
    logic          tbre_n, tsre_n, txd_n;

    // Receive path state
    logic [1:0]    rx_state, rx_state_n;
    logic [TW-1:0] rx_timer, rx_timer_n;
    logic [2:0]    rx_idx, rx_idx_n;
    logic [7:0]    rx_shift, rx_shift_n;
    logic [7:0]    dout_n;
    logic          data_ready_n, rx_overrun_n, rx_frame_err_n;

    // TX next state. A write needs tbre=1 and a transfer needs tbre=0, so the two never collide.
    always_comb begin
        tx_state_n = tx_state;
        tx_timer_n = tx_timer;
        tx_idx_n   = tx_idx;
        tx_shift_n = tx_shift;
        holding_n  = holding;
        tbre_n     = tbre;
        tsre_n     = tsre;
        txd_n      = txd;

        if (wr_rise && tbre) begin
            holding_n = din;
            tbre_n    = 1'b0;
        end

        case (tx_state)
            S_IDLE: begin
                if (!tbre && tsre) begin
                    tx_shift_n = holding;
                    tbre_n     = 1'b1;
                    tsre_n     = 1'b0;
                    tx_state_n = S_START;
                    tx_timer_n = '0;
                    txd_n      = 1'b0;
                end
            end
            S_START: begin
                if (tx_timer == BIT_LAST) begin
                    tx_timer_n = '0;
                    tx_idx_n   = 3'd0;
                    tx_state_n = S_DATA;
                    txd_n      = tx_shift[0];
                    tx_shift_n = {1'b0, tx_shift[7:1]};
                end else begin
                    tx_timer_n = tx_timer + TW'(1);
                end
            end
            S_DATA: begin
                if (tx_timer == BIT_LAST) begin
                    tx_timer_n = '0;
                    if (tx_idx == 3'd7) begin
                        tx_state_n = S_STOP;
                        txd_n      = 1'b1;
                    end else begin
                        tx_idx_n   = tx_idx + 3'd1;
                        txd_n      = tx_shift[0];
                        tx_shift_n = {1'b0, tx_shift[7:1]};
                    end
                end else begin
                    tx_timer_n = tx_timer + TW'(1);
                end
            end
            default: begin
                if (tx_timer == BIT_LAST) begin
                    tx_timer_n = '0;
                    tsre_n     = 1'b1;
                    tx_state_n = S_IDLE;
                end else begin
                    tx_timer_n = tx_timer + TW'(1);
                end
            end
        endcase
    end

    // RX next state. A commit that coincides with a read wins over the read.
    always_comb begin
        logic commit;
        commit         = 1'b0;
        rx_state_n     = rx_state;
        rx_timer_n     = rx_timer;
        rx_idx_n       = rx_idx;
        rx_shift_n     = rx_shift;
        dout_n         = dout;
        data_ready_n   = data_ready;
        rx_overrun_n   = rx_overrun;
        rx_frame_err_n = 1'b0;

        case (rx_state)
            S_IDLE: begin
                if (rx_fall) begin
                    rx_state_n = S_START;
                    rx_timer_n = '0;
                end
            end
            S_START: begin
                if (rx_timer == HALF_LAST) begin
                    rx_timer_n = '0;
                    rx_idx_n   = 3'd0;
                    rx_state_n = rx_bit ? S_IDLE : S_DATA;
                end else begin
                    rx_timer_n = rx_timer + TW'(1);
                end
            end
            S_DATA: begin
                if (rx_timer == BIT_LAST) begin
                    rx_timer_n = '0;
                    rx_shift_n = {rx_bit, rx_shift[7:1]};
                    if (rx_idx == 3'd7) begin
                        rx_state_n = S_STOP;
                    end else begin
                        rx_idx_n = rx_idx + 3'd1;
                    end
                end else begin
                    rx_timer_n = rx_timer + TW'(1);
                end
            end
            default: begin
                if (rx_timer == BIT_LAST) begin
                    rx_timer_n = '0;
                    rx_state_n = S_IDLE;
                    if (rx_bit) begin
                        commit = 1'b1;
                    end else begin
                        rx_frame_err_n = 1'b1;
                    end
                end else begin
                    rx_timer_n = rx_timer + TW'(1);
                end
            end
        endcase

        if (commit) begin
            dout_n       = rx_shift;
            data_ready_n = 1'b1;
            if (data_ready && !rd_rise) begin
                rx_overrun_n = 1'b1;
            end
        end else if (rd_rise) begin
            data_ready_n = 1'b0;
            rx_overrun_n = 1'b0;
        end
    end

    // State registers for both paths
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tx_state     <= S_IDLE;
            tx_timer     <= '0;
            tx_idx       <= 3'd0;
            tx_shift     <= 8'h00;
            holding      <= 8'h00;
            tbre         <= 1'b1;
            tsre         <= 1'b1;
            txd          <= 1'b1;
            rx_state     <= S_IDLE;
            rx_timer     <= '0;
            rx_idx       <= 3'd0;
            rx_shift     <= 8'h00;
            dout         <= 8'h00;
            data_ready   <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            tx_state     <= tx_state_n;
            tx_timer     <= tx_timer_n;
            tx_idx       <= tx_idx_n;
            tx_shift     <= tx_shift_n;
            holding      <= holding_n;
            tbre         <= tbre_n;
            tsre         <= tsre_n;
            txd          <= txd_n;
            rx_state     <= rx_state_n;
            rx_timer     <= rx_timer_n;
            rx_idx       <= rx_idx_n;
            rx_shift     <= rx_shift_n;
            dout         <= dout_n;
            data_ready   <= data_ready_n;
            rx_overrun   <= rx_overrun_n;
            rx_frame_err <= rx_frame_err_n;
        end
    end

endmodule

// File: tb/tb_uart_port.sv
// tb_uart_port: scoreboard bench for uart_port at 16 clocks per bit.
// Expected TX frames ({stop, data, start}) and RX bytes are queued as stimulus is driven.
// They are compared as the line monitor or the receive buffer produces output.
module tb_uart_port;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       wrn = 1'b1;
    logic       rdn = 1'b1;
    logic       data_ready, tbre, tsre, txd;
    logic       rxd = 1'b1;
    logic       rx_overrun, rx_frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fe_count = 0;

    logic [9:0] tx_exp[$];
    logic [9:0] tx_got[$];
    int         tx_start_t[$];
    logic [7:0] rx_exp[$];

    uart_port #(.CLKS_PER_BIT(CPB)) dut (
        .CLK(clk), .RST(rst), .din(din), .dout(dout), .wrn(wrn), .rdn(rdn),
        .data_ready(data_ready), .tbre(tbre), .tsre(tsre), .txd(txd), .rxd(rxd),
        .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (rx_frame_err === 1'b1) fe_count <= fe_count + 1;

    // Line monitor: on a start edge, sample mid-bit for start, 8 data bits and stop.
    initial begin : tx_mon
        logic       prev;
        logic [9:0] f;
        int         t;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && prev === 1'b1 && txd === 1'b0) begin
                t = cyc;
                repeat (CPB / 2) @(negedge clk);
                f[0] = txd;
                for (int i = 1; i < 10; i++) begin
                    repeat (CPB) @(negedge clk);
                    f[i] = txd;
                end
                tx_got.push_back(f);
                tx_start_t.push_back(t);
            end
            prev = txd;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cpu_write(input logic [7:0] b);
        din = b;
        wrn = 1'b0;
        tick(4);
        wrn = 1'b1;
    endtask

    task automatic cpu_read;
        rdn = 1'b0;
        tick(4);
        rdn = 1'b1;
        tick(4);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        rxd = stop;
        tick(CPB);
        rxd = 1'b1;
    endtask

    task automatic wait_tx(input int n, input string name);
        int budget = 0;
        while (tx_got.size() < n && budget < 800) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (tx_got.size() < n) begin
            errors++;
            $display("FAIL %s: %0d frames seen, %0d required", name, tx_got.size(), n);
        end
    endtask

    task automatic test_reset;
        logic [13:0] st;
        rst = 1'b0;
        tick(5);
        rst = 1'b1;
        tick(100);
        st = {txd, tbre, tsre, data_ready, rx_overrun, rx_frame_err, dout};
        checks++;
        if (st !== {6'b111000, 8'h00}) begin
            errors++;
            $display("FAIL reset_state: got %b required %b", st, {6'b111000, 8'h00});
        end
    endtask

    task automatic test_single_tx;
        logic       found = 1'b0;
        logic [9:0] got, exp;
        tx_exp.push_back({1'b1, 8'hA5, 1'b0});
        cpu_write(8'hA5);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (tbre === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL tbre_low: tbre=%b, required 0 within 3 cycles", tbre);
        end
        @(negedge clk);
        checks++;
        if (tbre !== 1'b1) begin
            errors++;
            $display("FAIL tbre_reload: got %b required 1", tbre);
        end
        checks++;
        if (tsre !== 1'b0) begin
            errors++;
            $display("FAIL tsre_busy: got %b required 0", tsre);
        end
        wait_tx(1, "single_frame_seen");
        got = (tx_got.size() > 0) ? tx_got.pop_front() : 10'bx;
        exp = tx_exp.pop_front();
        if (tx_start_t.size() > 0) void'(tx_start_t.pop_front());
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL single_frame: got %b required %b", got, exp);
        end
        tick(20);
        checks++;
        if ({tsre, tbre, txd} !== 3'b111) begin
            errors++;
            $display("FAIL tx_idle_after: got tsre,tbre,txd=%b required 111", {tsre, tbre, txd});
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] got, exp;
        int         t0, t1;
        tx_exp.push_back({1'b1, 8'h55, 1'b0});
        cpu_write(8'h55);
        tick(8);
        checks++;
        if (tbre !== 1'b1) begin
            errors++;
            $display("FAIL b2b_tbre_free: got %b required 1", tbre);
        end
        tx_exp.push_back({1'b1, 8'h0F, 1'b0});
        cpu_write(8'h0F);
        tick(4);
        checks++;
        if (tbre !== 1'b0) begin
            errors++;
            $display("FAIL b2b_tbre_full: got %b required 0", tbre);
        end
        cpu_write(8'hFF);
        wait_tx(2, "b2b_frames_seen");
        tick(400);
        checks++;
        if (tx_got.size() != 2) begin
            errors++;
            $display("FAIL b2b_frame_count: got %0d frames required 2", tx_got.size());
        end
        t0 = (tx_start_t.size() > 0) ? tx_start_t.pop_front() : 0;
        t1 = (tx_start_t.size() > 0) ? tx_start_t.pop_front() : 0;
        for (int k = 0; k < 2; k++) begin
            got = (tx_got.size() > 0) ? tx_got.pop_front() : 10'bx;
            exp = tx_exp.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL b2b_frame%0d: got %b required %b", k, got, exp);
            end
        end
        checks++;
        if (t1 - t0 < 160 || t1 - t0 > 161) begin
            errors++;
            $display("FAIL b2b_gap: start spacing %0d cycles, required 160..161", t1 - t0);
        end
        tx_got.delete();
        tx_start_t.delete();
    endtask

    task automatic test_rx;
        logic [9:0] st, want;
        logic [7:0] exp;
        rx_exp.push_back(8'h3C);
        send_rx(8'h3C, 1'b1);
        tick(4);
        exp = rx_exp.pop_front();
        st = {data_ready, rx_overrun, dout};
        want = {2'b10, exp};
        checks++;
        if (st !== want) begin
            errors++;
            $display("FAIL rx_first: got %b required %b", st, want);
        end
        cpu_read();
        st = {data_ready, rx_overrun, dout};
        want = {2'b00, exp};
        checks++;
        if (st !== want) begin
            errors++;
            $display("FAIL rx_read: got %b required %b", st, want);
        end
        rx_exp.push_back(8'h7E);
        send_rx(8'h7E, 1'b1);
        tick(4);
        exp = rx_exp.pop_front();
        st = {data_ready, rx_overrun, dout};
        want = {2'b10, exp};
        checks++;
        if (st !== want) begin
            errors++;
            $display("FAIL rx_unread: got %b required %b", st, want);
        end
        rx_exp.push_back(8'h81);
        send_rx(8'h81, 1'b1);
        tick(4);
        exp = rx_exp.pop_front();
        st = {data_ready, rx_overrun, dout};
        want = {2'b11, exp};
        checks++;
        if (st !== want) begin
            errors++;
            $display("FAIL rx_overrun: got %b required %b", st, want);
        end
        cpu_read();
        st = {data_ready, rx_overrun, dout};
        want = {2'b00, exp};
        checks++;
        if (st !== want) begin
            errors++;
            $display("FAIL rx_overrun_clear: got %b required %b", st, want);
        end
    endtask

    task automatic test_rx_errors;
        int fe0;
        fe0 = fe_count;
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        tick(40);
        checks++;
        if ({data_ready, dout, fe_count - fe0} !== {1'b0, 8'h81, 32'sd0}) begin
            errors++;
            $display("FAIL rx_glitch: got ready=%b dout=%h fe=%0d required 0 81 0",
                     data_ready, dout, fe_count - fe0);
        end
        send_rx(8'hA7, 1'b0);
        tick(4);
        checks++;
        if (fe_count - fe0 != 1) begin
            errors++;
            $display("FAIL frame_err_pulse: got %0d cycles high required 1", fe_count - fe0);
        end
        checks++;
        if ({data_ready, rx_overrun, dout} !== {2'b00, 8'h81}) begin
            errors++;
            $display("FAIL frame_err_buffer: got %b required %b",
                     {data_ready, rx_overrun, dout}, {2'b00, 8'h81});
        end
    endtask

    task automatic test_reset_mid;
        logic [9:0] got, exp;
        logic [7:0] rexp;
        fork
            send_rx(8'h5A, 1'b1);
            begin
                cpu_write(8'hC3);
                tick(4 + 4 * CPB + CPB / 2);
                rst = 1'b0;
                #1;
                checks++;
                if ({txd, tbre, tsre, data_ready, rx_overrun, rx_frame_err, dout} !== {6'b111000, 8'h00}) begin
                    errors++;
                    $display("FAIL reset_mid_immediate: got %b required %b",
                             {txd, tbre, tsre, data_ready, rx_overrun, rx_frame_err, dout},
                             {6'b111000, 8'h00});
                end
            end
        join
        tick(5);
        rst = 1'b1;
        tick(200);
        checks++;
        if ({txd, tbre, tsre, data_ready, dout} !== {4'b1110, 8'h00}) begin
            errors++;
            $display("FAIL reset_mid_release: got %b required %b",
                     {txd, tbre, tsre, data_ready, dout}, {4'b1110, 8'h00});
        end
        tx_got.delete();
        tx_start_t.delete();
        tx_exp.delete();
        rx_exp.delete();
        tx_exp.push_back({1'b1, 8'h96, 1'b0});
        rx_exp.push_back(8'h69);
        fork
            cpu_write(8'h96);
            send_rx(8'h69, 1'b1);
        join
        tick(4);
        rexp = rx_exp.pop_front();
        checks++;
        if ({data_ready, rx_overrun, dout} !== {2'b10, rexp}) begin
            errors++;
            $display("FAIL post_reset_rx: got %b required %b",
                     {data_ready, rx_overrun, dout}, {2'b10, rexp});
        end
        wait_tx(1, "post_reset_frame_seen");
        got = (tx_got.size() > 0) ? tx_got.pop_front() : 10'bx;
        exp = tx_exp.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL post_reset_tx: got %b required %b", got, exp);
        end
    endtask

    initial begin
        test_reset();
        test_single_tx();
        test_back_to_back();
        test_rx();
        test_rx_errors();
        test_reset_mid();
        tick(10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
